noc_local_packetizer: RTL
=========================

# noc_local_packetizer

Injection-side network interface between a tile's compute/DMA logic and the Local port (port 4) of the tile's 5-port NoC router. It accepts a message command (destination coordinates and payload length) and a stream of payload words. It serializes them into a head flit, zero or more body flits and a tail flit, and drives them through the router's valid/ready input handshake. A single registered output stage sustains one flit per cycle and holds flits stable under router backpressure.

## Interface
- FLIT_W, 64: flit width; payload per body/tail flit is FLIT_W-2 bits
- X_W, 4: mesh X coordinate width
- Y_W, 4: mesh Y coordinate width
- LEN_W, 4: payload-length field width; max payload 2^LEN_W-1 words
- SRC_X, 0: this tile's X coordinate, inserted in head flits
- SRC_Y, 0: this tile's Y coordinate, inserted in head flits

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  message command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_dest_x  in  X_W  destination X
- cmd_dest_y  in  Y_W  destination Y
- cmd_len  in  LEN_W  payload word count, 0..2^LEN_W-1
- data_valid  in  1  payload word present
- data_ready  out  1  payload word accepted when data_valid & data_ready
- data_in  in  FLIT_W-2  payload word
- flit_out  out  FLIT_W  flit to router Local input
- valid_out  out  1  flit_out valid
- ready_in  in  1  router Local input ready
- busy  out  1  a packet is in progress, or the output register holds a flit
- pkt_sent  out  16  count of completed packets

## Operation
- Flit type field is flit[FLIT_W-1:FLIT_W-2]:
  - 2'b01: head
  - 2'b00: body
  - 2'b10: tail
  - 2'b11: head+tail, used when len = 0
- Head flit layout, MSB down after the type field: dest_x, dest_y, SRC_X, SRC_Y, len. All remaining low bits are zero.
- Body/tail flit layout: flit[FLIT_W-3:0] = data_in. The word is not modified.
- Output register: out_valid drives valid_out. The register may load when load_ok = !out_valid | ready_in.
- FSM with states IDLE and PAYLOAD, plus a remaining-word counter rem (LEN_W bits).
- In IDLE:
  - cmd_ready = load_ok; data_ready = 0.
  - On command handshake, load the head flit.
  - If cmd_len = 0: type is 11 and the FSM stays in IDLE.
  - Otherwise: type is 01, rem := cmd_len, and the FSM goes to PAYLOAD.
- In PAYLOAD:
  - cmd_ready = 0; data_ready = load_ok.
  - On data handshake, load a body flit, or a tail flit when rem = 1. Then rem := rem-1.
  - When rem = 1 at the handshake, return to IDLE.
- If no new flit loads while ready_in = 1, out_valid clears. If ready_in = 0, flit_out and valid_out hold unchanged.
- pkt_sent increments by 1 when valid_out & ready_in and the flit type is 10 or 11. It wraps 0xFFFF -> 0x0000.
- busy = (state == PAYLOAD) | out_valid.
- A payload stall (data_valid = 0) inserts bubbles only. It never drops flits or reorders them.

## Timing
- Reset values: valid_out=0, flit_out=0, pkt_sent=0, busy=0, state=IDLE, rem=0. cmd_ready and data_ready are forced to 0 while rst = 1.
- Latency: a flit appears on flit_out/valid_out exactly 1 cycle after its cmd or data handshake.
- Throughput: 1 flit/cycle with ready_in held high. Packet of N payload words = N+1 consecutive flits. Back-to-back packets need no gap: a new command is accepted in the cycle after the tail handshake.
- Full output register with ready_in = 0: cmd_ready = data_ready = 0. Nothing is lost, and the held flit is stable until accepted.
- Simultaneous output drain and load in the same cycle: the new flit replaces the drained one, and valid_out stays 1.
- Reset mid-packet: the packet is abandoned and no tail is emitted. valid_out = 0 in the cycle after rst. The router must tolerate the truncated packet; upstream logic must not reset one side only.
- cmd_* and data_* must be held stable while valid is high and ready is low (standard valid/ready rule, checked by assertion).

## Test plan
- Single-flit packet: cmd dest=(3,2), len=0, ready_in=1 -> one cycle later flit_out type 11, dest_x=3, dest_y=2, len=0, valid_out=1 for 1 cycle; pkt_sent=1.
- 3-word packet: len=3, data words 0x1, 0x2, 0x3 with data_valid=1 -> 4 consecutive flits, types 01/00/00/10, payloads 0x1/0x2/0x3; busy drops after the tail.
- Backpressure: ready_in=0 for 5 cycles mid-packet -> flit_out stable, data_ready=0. Release -> remaining flits are delivered in order with no duplicates.
- Max length plus wrap: 15-word packets sent back-to-back with pkt_sent preloaded near 0xFFFF -> 16 flits per packet, no gap between packets, pkt_sent wraps to 0x0000.
- Payload bubbles: data_valid toggles every other cycle -> valid_out gaps match the bubbles, and the tail is still correctly marked.
- Reset mid-packet: assert rst after the head flit and one body flit -> valid_out=0 next cycle, state IDLE; a fresh len=1 packet afterwards emits 01 then 10.

Source files
------------

// File: rtl/noc_local_packetizer.sv
// noc_local_packetizer: serializes message commands and payload words into head/body/tail flits for the router Local port
module noc_local_packetizer #(
  parameter int FLIT_W = 64,
  parameter int X_W    = 4,
  parameter int Y_W    = 4,
  parameter int LEN_W  = 4,
  parameter int SRC_X  = 0,
  parameter int SRC_Y  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [X_W-1:0]    cmd_dest_x,
  input  logic [Y_W-1:0]    cmd_dest_y,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic [FLIT_W-3:0] data_in,
  output logic [FLIT_W-1:0] flit_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              busy,
  output logic [15:0]       pkt_sent
);
  localparam int PAD = FLIT_W - 2 - 2*X_W - 2*Y_W - LEN_W;
  localparam logic [X_W-1:0] SX = X_W'(SRC_X);
  localparam logic [Y_W-1:0] SY = Y_W'(SRC_Y);
  typedef enum logic {IDLE, PAYLOAD} state_t;
  state_t state, state_n;
  logic [LEN_W-1:0] rem, rem_n;
  logic [FLIT_W-1:0] flit_q, flit_n;
  logic out_valid, load_ok, cmd_hs, data_hs, last;
  logic [15:0] cnt;
  always_comb begin
    load_ok    = !out_valid | ready_in;
    cmd_ready  = !rst & (state == IDLE) & load_ok;
    data_ready = !rst & (state == PAYLOAD) & load_ok;
    cmd_hs     = cmd_valid & cmd_ready;
    data_hs    = data_valid & data_ready;
    last       = rem == LEN_W'(1);
    flit_n     = cmd_hs ? {(cmd_len == '0) ? 2'b11 : 2'b01, cmd_dest_x, cmd_dest_y, SX, SY, cmd_len, {PAD{1'b0}}}
                        : {last ? 2'b10 : 2'b00, data_in};
    state_n    = (cmd_hs && cmd_len != '0) ? PAYLOAD : (data_hs && last) ? IDLE : state;
    rem_n      = cmd_hs ? cmd_len : data_hs ? rem - LEN_W'(1) : rem;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rem       <= '0;
      flit_q    <= '0;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
      if (cmd_hs | data_hs) begin
        flit_q    <= flit_n;
        out_valid <= 1'b1;
      end else if (ready_in) begin
        out_valid <= 1'b0;
      end
      if (out_valid & ready_in & flit_q[FLIT_W-1]) cnt <= cnt + 16'd1;
    end
  end
  assign flit_out  = flit_q;
  assign valid_out = out_valid;
  assign busy      = (state == PAYLOAD) | out_valid;
  assign pkt_sent  = cnt;
  cmd_stable: assert property (@(posedge clk) disable iff (rst)
    cmd_valid && !cmd_ready |=> cmd_valid && $stable({cmd_dest_x, cmd_dest_y, cmd_len}));
  data_stable: assert property (@(posedge clk) disable iff (rst)
    data_valid && !data_ready |=> data_valid && $stable(data_in));
endmodule
